// File: rtl/element_bundle_cut_f.sv
// element_bundle_cut_f
//   Streaming float bundler for bipolar hypervectors. One dimension's run of
//   elements arrives over consecutive beats and is summed into one float. The
//   bipolar cut is applied to the sum, and one result element is presented.
//   The element format is {sign, exponent, mantissa} with an implicit hidden
//   bit.
//
//   Parameters:
//     EXPONENT_WIDTH - exponent field width
//     MANTISSA_WIDTH - stored mantissa width
//     CUT_ABS        - 1: clamp |x| to 1.0 and keep fractions
//                      0: hard sign, +/-1.0 only
//     MAX_RUN        - maximum number of elements in one run
//
//   Ports:
//     clk, reset_n         clock, asynchronous active-low reset
//     valid_in/ready_out   input beat handshake (elem_in, last_in)
//     valid_out/ready_in   result handshake (elem_out, count_out)
//     count_out            number of elements in the delivered run
//     ovf_out              (ELEMENT_BUNDLE_CUT_OVF_EN only) sticky per-run
//                          flag: an add saturated or took an inf/NaN input
//
//   Optional build macro: ELEMENT_BUNDLE_CUT_OVF_EN adds ovf_out.
module element_bundle_cut_f #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int CUT_ABS        = 1,
    parameter int MAX_RUN        = 255
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   valid_in,
    output logic                                   ready_out,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] elem_in,
    input  logic                                   last_in,
    output logic                                   valid_out,
    input  logic                                   ready_in,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] elem_out,
    output logic [$clog2(MAX_RUN+1)-1:0]           count_out
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
    ,
    output logic                                   ovf_out
`endif
);
    localparam int E      = EXPONENT_WIDTH;
    localparam int M      = MANTISSA_WIDTH;
    localparam int W      = E + M + 1;
    localparam int CW     = $clog2(MAX_RUN + 1);
    localparam int EMAX   = (1 << E) - 1;
    localparam int BIAS_I = (1 << (E - 1)) - 1;
    localparam logic [E-1:0] BIAS = E'(BIAS_I);
    localparam logic [E-1:0] EFIN = E'(EMAX - 1);

    typedef enum logic [1:0] {ACCUM, CUT, OUT} state_t;

    state_t        state_q;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q;
    logic          valid_q;
    logic [W-1:0]  elem_q;
    logic [CW-1:0] count_q;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
    logic          ovf_acc_q;
    logic          ovf_q;
    logic          ovf_d;
`endif

    // ------------------------------------------------------------------
    // acc_q + elem_in, truncating float add
    // ------------------------------------------------------------------
    logic          a_s, b_s, big_s, b_inf, sat;
    logic [E-1:0]  a_e, b_e, big_e, sml_e, d_e;
    logic [M:0]    a_m, b_m, big_m, sml_m, sml_sh;
    logic [M+1:0]  sum;
    logic [M:0]    norm;
    int            lz;
    int            res_e;
    logic [W-1:0]  sum_d;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        // Zero/denormal operands become +0 (hidden bit cleared too).
        a_s = acc_q[W-1];
        a_e = acc_q[W-2:M];
        a_m = {1'b1, acc_q[M-1:0]};
        if (a_e == '0) begin
            a_s = 1'b0;
            a_m = '0;
        end
        b_s   = elem_in[W-1];
        b_e   = elem_in[W-2:M];
        b_m   = {1'b1, elem_in[M-1:0]};
        b_inf = &b_e;
        if (b_e == '0) begin
            b_s = 1'b0;
            b_m = '0;
        end else if (b_inf) begin
            // inf/NaN enters as max finite of the same sign
            b_e = EFIN;
            b_m = '1;
        end

        // Order by magnitude so the subtraction never goes negative.
        if ({a_e, a_m} >= {b_e, b_m}) begin
            big_s = a_s; big_e = a_e; big_m = a_m;
            sml_e = b_e; sml_m = b_m;
        end else begin
            big_s = b_s; big_e = b_e; big_m = b_m;
            sml_e = a_e; sml_m = a_m;
        end
        d_e    = big_e - sml_e;
        sml_sh = sml_m >> d_e;
        if (a_s == b_s) sum = {1'b0, big_m} + {1'b0, sml_sh};
        else            sum = {1'b0, big_m} - {1'b0, sml_sh};

        // Leading-zero count below the carry bit: highest set bit wins.
        lz = 0;
        for (int i = 0; i <= M; i++) begin
            if (sum[i]) lz = M - i;
        end
        norm  = sum[M:0] << lz;
        res_e = sum[M+1] ? int'(big_e) + 1 : int'(big_e) - lz;

        sat   = 1'b0;
        sum_d = '0;
        if (sum == '0) begin
            sum_d = '0;                          // exact cancellation -> +0
        end else if (res_e >= EMAX) begin
            sat   = 1'b1;
            sum_d = {big_s, EFIN, {M{1'b1}}};
        end else if (res_e <= 0) begin
            sum_d = '0;                          // underflow flushes to +0
        end else begin
            sum_d = {big_s, res_e[E-1:0], sum[M+1] ? sum[M:1] : norm[M-1:0]};
        end
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        ovf_d = b_inf | sat;
`endif
        cnt_inc = cnt_q + CW'(1);
    end

    // ------------------------------------------------------------------
    // Bipolar cut of the finished sum
    // ------------------------------------------------------------------
    logic [W-1:0] cut_d;

    always_comb begin
        if (CUT_ABS != 0) begin
            cut_d = (acc_q[W-2:M] >= BIAS) ? {acc_q[W-1], BIAS, {M{1'b0}}} : acc_q;
        end else begin
            // +0 has no sign to keep; it resolves to +1.0
            cut_d = (acc_q[W-2:M] == '0) ? {1'b0, BIAS, {M{1'b0}}}
                                         : {acc_q[W-1], BIAS, {M{1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // ACCUM -> CUT -> OUT -> ACCUM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            elem_q    <= '0;
            count_q   <= '0;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (valid_in && ready_q) begin
                        acc_q <= sum_d;
                        cnt_q <= cnt_inc;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
                        ovf_acc_q <= ovf_acc_q | ovf_d;
`endif
                        // A full run is closed even without last_in.
                        if (last_in || cnt_inc == CW'(MAX_RUN)) begin
                            state_q <= CUT;
                            ready_q <= 1'b0;
                        end
                    end
                end
                CUT: begin
                    elem_q  <= cut_d;
                    count_q <= cnt_q;
                    valid_q <= 1'b1;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
                    ovf_q   <= ovf_acc_q;
`endif
                    state_q <= OUT;
                end
                OUT: begin
                    if (ready_in) begin
                        valid_q   <= 1'b0;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        ready_q   <= 1'b1;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
                        ovf_acc_q <= 1'b0;
                        ovf_q     <= 1'b0;
`endif
                        state_q   <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign elem_out  = elem_q;
    assign count_out = count_q;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
    assign ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_element_bundle_cut_f.sv
// Directed bench for element_bundle_cut_f. Three instances:
//   0: CUT_ABS=1, MAX_RUN=255   1: CUT_ABS=0, MAX_RUN=255
//   2: CUT_ABS=1, MAX_RUN=4
module tb_element_bundle_cut_f;
    logic clk;
    logic reset_n;
    logic [2:0]       vin, lst, rdyin, rdyo, vo;
    logic [2:0][31:0] ein, eo;
    logic [7:0]       co0, co1;
    logic [2:0]       co2;
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
    logic [2:0]       ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    element_bundle_cut_f #(.CUT_ABS(1), .MAX_RUN(255)) u0 (
        .clk(clk), .reset_n(reset_n), .valid_in(vin[0]), .ready_out(rdyo[0]),
        .elem_in(ein[0]), .last_in(lst[0]), .valid_out(vo[0]), .ready_in(rdyin[0]),
        .elem_out(eo[0]), .count_out(co0)
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        , .ovf_out(ovf[0])
`endif
    );
    element_bundle_cut_f #(.CUT_ABS(0), .MAX_RUN(255)) u1 (
        .clk(clk), .reset_n(reset_n), .valid_in(vin[1]), .ready_out(rdyo[1]),
        .elem_in(ein[1]), .last_in(lst[1]), .valid_out(vo[1]), .ready_in(rdyin[1]),
        .elem_out(eo[1]), .count_out(co1)
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        , .ovf_out(ovf[1])
`endif
    );
    element_bundle_cut_f #(.CUT_ABS(1), .MAX_RUN(4)) u2 (
        .clk(clk), .reset_n(reset_n), .valid_in(vin[2]), .ready_out(rdyo[2]),
        .elem_in(ein[2]), .last_in(lst[2]), .valid_out(vo[2]), .ready_in(rdyin[2]),
        .elem_out(eo[2]), .count_out(co2)
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        , .ovf_out(ovf[2])
`endif
    );

    function automatic logic [31:0] cnt(input int idx);
        case (idx)
            0:       return 32'(co0);
            1:       return 32'(co1);
            default: return 32'(co2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the beat is taken at the following posedge.
    task automatic send(input int idx, input logic [31:0] d, input logic l);
        vin[idx] = 1'b1;
        ein[idx] = d;
        lst[idx] = l;
        @(negedge clk);
        vin[idx] = 1'b0;
        lst[idx] = 1'b0;
    endtask

    task automatic wait_valid(input int idx, input string tag);
        int n = 0;
        while (!vo[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(vo[idx]), 32'd1);
    endtask

    task automatic check_out(input int idx, input string tag,
                             input logic [31:0] e, input logic [31:0] c);
        check({tag, "_elem"}, eo[idx], e);
        check({tag, "_count"}, cnt(idx), c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        vin     = '0;
        lst     = '0;
        ein     = '0;
        rdyin   = '1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(rdyo), 32'd0);
        check("rst_valid", 32'(vo), 32'd0);
        check("rst_elem0", eo[0], 32'd0);
        check("rst_elem2", eo[2], 32'd0);
        check("rst_count0", cnt(0), 32'd0);
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(rdyo), 32'd7);

        // 0.5 + 0.25, latency to valid_out
        send(0, 32'h3F000000, 1'b0);
        send(0, 32'h3E800000, 1'b1);
        check("lat_cut_valid", 32'(vo[0]), 32'd0);
        check("lat_cut_ready", 32'(rdyo[0]), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(vo[0]), 32'd1);
        check_out(0, "sum075", 32'h3F400000, 32'd2);
        @(negedge clk);
        check("hs_valid_drop", 32'(vo[0]), 32'd0);
        check("hs_ready", 32'(rdyo[0]), 32'd1);

        // 1 + 2 - 1 = 2.0, clamped
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'h40000000, 1'b0);
        send(0, 32'hBF800000, 1'b1);
        wait_valid(0, "clamp");
        check_out(0, "clamp", 32'h3F800000, 32'd3);
        @(negedge clk);

        // Hard sign: +0 -> +1.0, -0.25 -> -1.0
        send(1, 32'h3F800000, 1'b0);
        send(1, 32'hBF800000, 1'b1);
        wait_valid(1, "sgn_zero");
        check_out(1, "sgn_zero", 32'h3F800000, 32'd2);
        @(negedge clk);
        send(1, 32'hBE800000, 1'b1);
        wait_valid(1, "sgn_neg");
        check_out(1, "sgn_neg", 32'hBF800000, 32'd1);
        @(negedge clk);

        // Backpressure: result held, input beats refused
        rdyin[0] = 1'b0;
        send(0, 32'h3E800000, 1'b1);
        wait_valid(0, "hold");
        check_out(0, "hold_pass", 32'h3E800000, 32'd1);
        vin[0] = 1'b1;
        ein[0] = 32'h3F800000;
        lst[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(vo[0]), 32'd1);
            check("hold_elem", eo[0], 32'h3E800000);
            check("hold_ready", 32'(rdyo[0]), 32'd0);
        end
        vin[0]   = 1'b0;
        lst[0]   = 1'b0;
        rdyin[0] = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(vo[0]), 32'd0);
        check("release_ready", 32'(rdyo[0]), 32'd1);
        send(0, 32'h3F000000, 1'b1);
        wait_valid(0, "after_hold");
        check_out(0, "after_hold", 32'h3F000000, 32'd1);
        @(negedge clk);

        // Reset mid-run discards the partial sum
        send(0, 32'h3F000000, 1'b0);
        send(0, 32'h3F000000, 1'b0);
        send(0, 32'h3F000000, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rdyo[0]), 32'd0);
        check("midrst_valid", 32'(vo[0]), 32'd0);
        check("midrst_elem", eo[0], 32'd0);
        check("midrst_count", cnt(0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, 32'h3F000000, 1'b1);
        wait_valid(0, "post_rst");
        check_out(0, "post_rst", 32'h3F000000, 32'd1);
        @(negedge clk);

        // MAX_RUN=4: forced end without last_in
        send(2, 32'h3E800000, 1'b0);
        send(2, 32'h3E800000, 1'b0);
        send(2, 32'h3E800000, 1'b0);
        send(2, 32'h3E800000, 1'b0);
        check("forced_cut_valid", 32'(vo[2]), 32'd0);
        check("forced_cut_ready", 32'(rdyo[2]), 32'd0);
        @(negedge clk);
        check("forced_valid", 32'(vo[2]), 32'd1);
        check_out(2, "forced", 32'h3F800000, 32'd4);
        @(negedge clk);

        // Infinity input behaves as max finite, then clamps
        send(2, 32'h7F800000, 1'b1);
        wait_valid(2, "inf");
        check_out(2, "inf", 32'h3F800000, 32'd1);
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        check("inf_ovf", 32'(ovf[2]), 32'd1);
`endif
        @(negedge clk);
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        check("ovf_cleared", 32'(ovf[2]), 32'd0);
`endif
        send(2, 32'h3F000000, 1'b1);
        wait_valid(2, "after_inf");
        check_out(2, "after_inf", 32'h3F000000, 32'd1);
`ifdef ELEMENT_BUNDLE_CUT_OVF_EN
        check("after_inf_ovf", 32'(ovf[2]), 32'd0);
`endif
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
